// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width default, ALU op codes and arbiter FSM states
package alu_arbiter_pkg;
    localparam int DW_DEF = 4;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// alu_arbiter_rr_arb2: two-way one-hot grant, round-robin on ties.
// ALU_ARB_FIXED_PRIO_EN: req0 always wins a tie and no last-grant input exists.
module alu_arbiter_rr_arb2 (
    input  logic       i_en,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic       i_last,
`endif
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        o_grant = !i_en ? 2'b00 : i_valid[0] ? 2'b01 : {i_valid[1], 1'b0};
`else
        o_grant = !i_en ? 2'b00 : &i_valid ? (i_last ? 2'b01 : 2'b10) : i_valid;
`endif
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two valid/ready requesters.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority to req0 instead of round-robin.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [1:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [1:0]    req1_op,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_sum,
    output logic          rsp0_cout,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_sum,
    output logic          rsp1_cout,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_s,
    input  logic [DW-1:0] alu_sum,
    input  logic          alu_cout,
    output logic          busy
);
    state_t        r_state;
    logic          r_gsel;
    logic [DW-1:0] r_a, r_b, r_sum0, r_sum1;
    logic [1:0]    r_s;
    logic          r_cout0, r_cout1, r_rv0, r_rv1;
    logic [1:0]    w_grant;
    logic          w_cout, w_ack;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic          r_last;
`endif
    alu_arbiter_rr_arb2 u_arb (
        .i_en    (r_state == ST_IDLE),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .i_last  (r_last),
`endif
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );
    // the ALU reports its adder carry for every select; only ADD exposes it
    assign w_cout     = (r_s == OP_ADD) & alu_cout;
    assign w_ack      = r_gsel ? rsp1_ready : rsp0_ready;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp0_valid = r_rv0;
    assign rsp1_valid = r_rv1;
    assign rsp0_sum   = r_sum0;
    assign rsp1_sum   = r_sum1;
    assign rsp0_cout  = r_cout0;
    assign rsp1_cout  = r_cout1;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_s      = r_s;
    assign busy       = r_state != ST_IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gsel  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= OP_ADD;
            r_sum0  <= '0;
            r_sum1  <= '0;
            r_cout0 <= 1'b0;
            r_cout1 <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last  <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (|w_grant) begin
                    r_a     <= w_grant[1] ? req1_a  : req0_a;
                    r_b     <= w_grant[1] ? req1_b  : req0_b;
                    r_s     <= w_grant[1] ? req1_op : req0_op;
                    r_gsel  <= w_grant[1];
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_gsel) begin
                        r_sum1  <= alu_sum;
                        r_cout1 <= w_cout;
                        r_rv1   <= 1'b1;
                    end else begin
                        r_sum0  <= alu_sum;
                        r_cout0 <= w_cout;
                        r_rv0   <= 1'b1;
                    end
`ifndef ALU_ARB_FIXED_PRIO_EN
                    r_last  <= r_gsel;
`endif
                    r_state <= ST_RESP;
                end
                ST_RESP: if (w_ack) begin
                    r_rv0   <= 1'b0;
                    r_rv1   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural 4-bit ALU.
// Define ALU_ARB_FIXED_PRIO_EN to expect fixed-priority grants.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp0_cout, rsp1_valid, rsp1_ready, rsp1_cout;
    logic [3:0] rsp0_sum, rsp1_sum;
    logic [3:0] alu_a, alu_b, alu_sum;
    logic [1:0] alu_s;
    logic       alu_cout, busy;
    logic [4:0] w_add, w_inc;
    logic [4:0] q0[$], q1[$];
    int         order[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    // stand-in for the shared ALU: carry always comes from its adder path
    assign w_add = {1'b0, alu_a} + {1'b0, alu_b};
    assign w_inc = {1'b0, alu_a} + 5'd1;
    always_comb begin
        alu_sum  = alu_s == 2'b00 ? w_add[3:0] : alu_s == 2'b01 ? (alu_a | alu_b) :
                   alu_s == 2'b10 ? (alu_a & alu_b) : w_inc[3:0];
        alu_cout = alu_s == 2'b11 ? w_inc[4] : w_add[4];
    end

    alu_arbiter #(.DW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_sum(alu_sum), .alu_cout(alu_cout), .busy(busy)
    );

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [4:0] s;
        logic [3:0] inc;
        s   = {1'b0, a} + {1'b0, b};
        inc = a + 4'd1;
        case (op)
            2'b00:   return s;
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, inc};
        endcase
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int ch, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        if (ch == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // holds valid until accepted (bounded), records the expected result; returns at the negedge after acceptance
    task automatic send(input int ch, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, output bit ok);
        drive(ch, 1'b1, a, b, op);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (ch == 0 ? req0_ready : req1_ready) begin
                if (ch == 0) q0.push_back(model(a, b, op));
                else q1.push_back(model(a, b, op));
                ok = 1'b1;
            end
            cyc();
        end
        drive(ch, 1'b0, a, b, op);
    endtask

    task automatic wait_rsp(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ch == 0 ? rsp0_valid : rsp1_valid) ok = 1'b1;
            else cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_s} !== 10'b0) begin
            failures++; $display("FAIL reset_alu: got %h want 000", {alu_a, alu_b, alu_s});
        end
        checks++;
        if ({rsp0_sum, rsp0_cout, rsp1_sum, rsp1_cout} !== 10'b0) begin
            failures++; $display("FAIL reset_rsp: got %h want 000", {rsp0_sum, rsp0_cout, rsp1_sum, rsp1_cout});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_latency();
        logic [4:0] e;
        drive(0, 1'b1, 4'h5, 4'h6, 2'b00);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL lat_ready: got %b want 10", {req0_ready, req1_ready});
        end
        q0.push_back(model(4'h5, 4'h6, 2'b00));
        cyc();
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        checks++;
        if ({busy, rsp0_valid, alu_a, alu_b, alu_s} !== {2'b10, 4'h5, 4'h6, 2'b00}) begin
            failures++; $display("FAIL lat_exec: got %h want %h", {busy, rsp0_valid, alu_a, alu_b, alu_s}, {2'b10, 4'h5, 4'h6, 2'b00});
        end
        cyc();
        e = q0.pop_front();
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum} !== {2'b10, e}) begin
            failures++; $display("FAIL lat_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum}, {2'b10, e});
        end
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        checks++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL lat_done: got %b want 00", {rsp0_valid, busy});
        end
    endtask

    task automatic test_add_inc();
        bit ok;
        logic [4:0] e;
        logic [3:0] va [2] = '{4'h3, 4'h0};
        logic [1:0] vo [2] = '{2'b00, 2'b11};
        for (int k = 0; k < 2; k++) begin
            send(1, 4'hF, va[k], vo[k], ok);
            if (ok) wait_rsp(1, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL addinc_timeout: got no response want response op=%0d", vo[k]);
                q1.delete();
                return;
            end
            e = q1.pop_front();
            checks++;
            if ({rsp1_cout, rsp1_sum} !== e) begin
                failures++; $display("FAIL addinc_result op=%0d: got %h want %h", vo[k], {rsp1_cout, rsp1_sum}, e);
            end
            checks++;
            if ({rsp0_valid, rsp0_cout, rsp0_sum} !== {2'b00, 4'hB}) begin
                failures++; $display("FAIL addinc_other_hold: got %h want 0b", {rsp0_valid, rsp0_cout, rsp0_sum});
            end
            rsp1_ready = 1'b1;
            cyc();
            rsp1_ready = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int n0 = 0, n1 = 0, got = 0;
        logic [4:0] e;
        pulse_rst();
        order.delete();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            req0_a = 4'(n0 * 5 + 3); req0_b = 4'(n0 + 9); req0_op = 2'(n0);
            req1_a = 4'(4'hA + n1 * 3); req1_b = 4'(n1 + 7); req1_op = 2'(n1 + 1);
            #1;
            if (req0_ready) begin q0.push_back(model(req0_a, req0_b, req0_op)); order.push_back(0); n0++; end
            if (req1_ready) begin q1.push_back(model(req1_a, req1_b, req1_op)); order.push_back(1); n1++; end
            if (rsp0_valid && q0.size() > 0) begin
                e = q0.pop_front(); got++; checks++;
                if ({rsp0_cout, rsp0_sum} !== e) begin
                    failures++; $display("FAIL rr_rsp0: got %h want %h", {rsp0_cout, rsp0_sum}, e);
                end
            end
            if (rsp1_valid && q1.size() > 0) begin
                e = q1.pop_front(); got++; checks++;
                if ({rsp1_cout, rsp1_sum} !== e) begin
                    failures++; $display("FAIL rr_rsp1: got %h want %h", {rsp1_cout, rsp1_sum}, e);
                end
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (got != 6 || order.size() != 6) begin
            failures++; $display("FAIL rr_count: got %0d responses %0d grants want 6 6", got, order.size());
        end
        for (int i = 0; i < order.size() && i < 6; i++) begin
            checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (order[i] != 0) begin
                failures++; $display("FAIL rr_order[%0d]: got %0d want 0", i, order[i]);
            end
`else
            if (order[i] != i % 2) begin
                failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2);
            end
`endif
        end
        cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic test_hold();
        bit ok;
        logic [4:0] e;
        pulse_rst();
        drive(1, 1'b1, 4'hC, 4'hA, 2'b10);
        send(0, 4'h5, 4'h6, 2'b01, ok);
        if (ok) wait_rsp(0, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL hold_timeout: got no response want response");
            drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
            q0.delete();
            return;
        end
        e = q0.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp0_valid, rsp0_cout, rsp0_sum} !== {1'b1, e}) begin
                failures++; $display("FAIL hold_rsp cyc%0d: got %h want %h", i, {rsp0_valid, rsp0_cout, rsp0_sum}, {1'b1, e});
            end
            checks++;
            if ({req0_ready, req1_ready, rsp1_valid} !== 3'b000) begin
                failures++; $display("FAIL hold_ready cyc%0d: got %b want 000", i, {req0_ready, req1_ready, rsp1_valid});
            end
            cyc();
        end
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, busy, req1_ready} !== 3'b001) begin
            failures++; $display("FAIL hold_release: got %b want 001", {rsp0_valid, busy, req1_ready});
        end
        q1.push_back(model(4'hC, 4'hA, 2'b10));
        cyc();
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        wait_rsp(1, ok);
        e = q1.pop_front();
        checks++;
        if (!ok || {rsp1_cout, rsp1_sum} !== e) begin
            failures++; $display("FAIL hold_next: got %h ok=%0d want %h", {rsp1_cout, rsp1_sum}, ok, e);
        end
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_rst_exec();
        bit ok, seen;
        logic [4:0] e;
        send(1, 4'hC, 4'hA, 2'b10, ok);
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++; $display("FAIL rst_exec_busy: got busy=%b ok=%0d want 1", busy, ok);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q1.delete();
        checks++;
        if ({busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_s, rsp1_sum, rsp1_cout} !== 20'b0) begin
            failures++; $display("FAIL rst_exec_outputs: got %h want 0",
                {busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_s, rsp1_sum, rsp1_cout});
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= rsp1_valid | busy;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL rst_exec_no_rsp: got %b want 0", seen);
        end
        drive(1, 1'b1, 4'h1, 4'h1, 2'b00);
        drive(0, 1'b1, 4'h3, 4'h4, 2'b00);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++; $display("FAIL rst_exec_first: got %b want 10", {req0_ready, req1_ready});
        end
        q0.push_back(model(4'h3, 4'h4, 2'b00));
        cyc();
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        drive(1, 1'b0, 4'h0, 4'h0, 2'b00);
        wait_rsp(0, ok);
        e = q0.pop_front();
        checks++;
        if (!ok || {rsp0_cout, rsp0_sum} !== e) begin
            failures++; $display("FAIL rst_exec_next: got %h ok=%0d want %h", {rsp0_cout, rsp0_sum}, ok, e);
        end
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_drop();
        bit ok, seen;
        logic [4:0] e;
        send(1, 4'h2, 4'h3, 2'b00, ok);
        drive(0, 1'b1, 4'h7, 4'h7, 2'b00);
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++; $display("FAIL drop_ready: got %b want 0", req0_ready);
        end
        cyc();
        drive(0, 1'b0, 4'h0, 4'h0, 2'b00);
        wait_rsp(1, ok);
        e = q1.pop_front();
        checks++;
        if (!ok || {rsp1_cout, rsp1_sum} !== e) begin
            failures++; $display("FAIL drop_rsp1: got %h ok=%0d want %h", {rsp1_cout, rsp1_sum}, ok, e);
        end
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= busy | rsp0_valid;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL drop_never_accepted: got %b want 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_latency();
        test_add_inc();
        test_round_robin();
        test_hold();
        test_rst_exec();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
